// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the fetch stage: next-PC op encodings, reset PC and NOP word.
package cpu_defs;

  typedef enum logic [2:0] {
    NPC_SEQ = 3'd0,
    NPC_BEQ = 3'd1,
    NPC_BNE = 3'd2,
    NPC_J   = 3'd3,
    NPC_JR  = 3'd4
  } npc_op_e;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  // Branch target is relative to the branch's own PC plus 4, offset in words.
  function automatic logic [31:0] branch_target(input logic [31:0] pc_d,
                                                input logic [15:0] imm16);
    return pc_d + 32'd4 + {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_unit_npc_calc.sv
// Combinational next-PC selection for the D-stage branch/jump controls.
module npc_calc
  import cpu_defs::*;
(
  input  logic [31:0] i_pc_F,
  input  logic [31:0] i_pc_D,
  input  logic [2:0]  i_npc_op_D,
  input  logic        i_cmp_zero,
  input  logic [15:0] i_imm16_D,
  input  logic [25:0] i_index26_D,
  input  logic [31:0] i_rs_fwd_D,
  output logic [31:0] o_next_pc,
  output logic        o_redirect
);

  logic [31:0] w_seq_pc;
  logic [31:0] w_br_pc;
  logic [31:0] w_jmp_pc;

  assign w_seq_pc = i_pc_F + 32'd4;
  assign w_br_pc  = branch_target(i_pc_D, i_imm16_D);
  assign w_jmp_pc = {i_pc_D[31:28], i_index26_D, 2'b00};

  always_comb begin
    o_next_pc  = w_seq_pc;
    o_redirect = 1'b0;
    case (i_npc_op_D)
      NPC_BEQ: begin
        if (i_cmp_zero) begin
          o_next_pc  = w_br_pc;
          o_redirect = 1'b1;
        end
      end
      NPC_BNE: begin
        if (!i_cmp_zero) begin
          o_next_pc  = w_br_pc;
          o_redirect = 1'b1;
        end
      end
      NPC_J: begin
        o_next_pc  = w_jmp_pc;
        o_redirect = 1'b1;
      end
      NPC_JR: begin
        o_next_pc  = i_rs_fwd_D;
        o_redirect = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// PC register and F/D pipeline register; delayed-branch fetch, so nothing is ever flushed.
module fetch_pc_unit
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic [31:0] i_instr_F,
  input  logic [2:0]  i_npc_op_D,
  input  logic        i_cmp_zero,
  input  logic [15:0] i_imm16_D,
  input  logic [25:0] i_index26_D,
  input  logic [31:0] i_rs_fwd_D,
  output logic [31:0] o_pc_F,
  output logic [31:0] o_instr_D,
  output logic [31:0] o_pc_D,
  output logic [31:0] o_pc8_D,
  output logic        o_redirect_D
);

  logic [31:0] r_pc_F;
  logic [31:0] r_instr_D;
  logic [31:0] r_pc_D;
  logic [31:0] w_next_pc;

  npc_calc u_npc_calc (
    .i_pc_F      (r_pc_F),
    .i_pc_D      (r_pc_D),
    .i_npc_op_D  (i_npc_op_D),
    .i_cmp_zero  (i_cmp_zero),
    .i_imm16_D   (i_imm16_D),
    .i_index26_D (i_index26_D),
    .i_rs_fwd_D  (i_rs_fwd_D),
    .o_next_pc   (w_next_pc),
    .o_redirect  (o_redirect_D)
  );

  // A stalled cycle drops the redirect; it is recomputed with fresh operands next cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pc_F    <= RESET_PC;
      r_instr_D <= NOP_INSTR;
      r_pc_D    <= 32'h0000_0000;
    end else if (!i_stall) begin
      r_pc_F    <= w_next_pc;
      r_instr_D <= i_instr_F;
      r_pc_D    <= r_pc_F;
    end
  end

  assign o_pc_F    = r_pc_F;
  assign o_instr_D = r_instr_D;
  assign o_pc_D    = r_pc_D;
  assign o_pc8_D   = r_pc_D + 32'd8;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit with hand-computed expected PCs.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] instr_F = 32'h0;
  logic [2:0]  npc_op = 3'd0;
  logic        cmp_zero = 1'b0;
  logic [15:0] imm16 = 16'h0;
  logic [25:0] index26 = 26'h0;
  logic [31:0] rs_fwd = 32'h0;
  logic [31:0] pc_F, instr_D, pc_D, pc8_D;
  logic        redirect;

  int n_checks = 0;
  int n_errors = 0;

  fetch_pc_unit dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_stall      (stall),
    .i_instr_F    (instr_F),
    .i_npc_op_D   (npc_op),
    .i_cmp_zero   (cmp_zero),
    .i_imm16_D    (imm16),
    .i_index26_D  (index26),
    .i_rs_fwd_D   (rs_fwd),
    .o_pc_F       (pc_F),
    .o_instr_D    (instr_D),
    .o_pc_D       (pc_D),
    .o_pc8_D      (pc8_D),
    .o_redirect_D (redirect)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after an edge; reset pulses high and releases before the next edge.
  task automatic do_reset();
    reset  = 1'b1;
    stall  = 1'b0;
    npc_op = 3'd0;
    #2;
    reset  = 1'b0;
  endtask

  task automatic seq_steps(input int n);
    npc_op = 3'd0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    // 1. reset asserted mid-cycle, effective without a clock edge
    #3;
    reset = 1'b1;
    #1;
    check("rst_pc_F", pc_F, 32'h0000_3000);
    check("rst_instr_D", instr_D, 32'h0);
    check("rst_pc_D", pc_D, 32'h0);
    check("rst_pc8_D", pc8_D, 32'h8);
    @(negedge clk);
    @(negedge clk);
    // stall held across the reset-release cycle
    stall = 1'b1;
    reset = 1'b0;
    step();
    check("rel_stall_pc_F", pc_F, 32'h0000_3000);
    check("rel_stall_pc_D", pc_D, 32'h0);
    stall = 1'b0;

    // 2. five sequential fetches
    check("seq0_pc_F", pc_F, 32'h0000_3000);
    npc_op = 3'd0;
    for (int k = 1; k <= 5; k++) begin
      instr_F = 32'hC0DE_0000 + 32'(k);
      cmp_zero = k[0];
      imm16 = 16'h8000;
      rs_fwd = 32'hDEAD_BEEF;
      check("seq_redirect", {31'b0, redirect}, 32'h0);
      step();
      check("seq_pc_F", pc_F, 32'h0000_3000 + 32'(4 * k));
      check("seq_pc_D", pc_D, 32'h0000_3000 + 32'(4 * (k - 1)));
      check("seq_instr_D", instr_D, 32'hC0DE_0000 + 32'(k));
    end

    // 3a. BEQ taken at pc_D = 0x3008
    do_reset();
    seq_steps(3);
    check("beq_pre_pc_D", pc_D, 32'h0000_3008);
    npc_op = 3'd1; imm16 = 16'h0003; cmp_zero = 1'b1;
    #1;
    check("beq_t_redirect", {31'b0, redirect}, 32'h1);
    step();
    check("beq_t_pc_F", pc_F, 32'h0000_3018);
    check("beq_t_slot_pc_D", pc_D, 32'h0000_300C);
    npc_op = 3'd0;
    step();
    check("beq_t_target_pc_D", pc_D, 32'h0000_3018);

    // 3b. BEQ not taken
    do_reset();
    seq_steps(3);
    npc_op = 3'd1; imm16 = 16'h0003; cmp_zero = 1'b0;
    #1;
    check("beq_nt_redirect", {31'b0, redirect}, 32'h0);
    step();
    check("beq_nt_pc_F", pc_F, 32'h0000_3010);

    // 4. BNE back-to-self, then J
    do_reset();
    seq_steps(5);
    check("bne_pre_pc_D", pc_D, 32'h0000_3010);
    npc_op = 3'd2; imm16 = 16'hFFFF; cmp_zero = 1'b0;
    #1;
    check("bne_redirect", {31'b0, redirect}, 32'h1);
    step();
    check("bne_pc_F", pc_F, 32'h0000_3010);
    seq_steps(5);
    check("j_pre_pc_D", pc_D, 32'h0000_3020);
    npc_op = 3'd3; index26 = 26'h0000C00;
    step();
    check("j_pc_F", pc_F, 32'h0000_3000);
    check("j_pc_D", pc_D, 32'h0000_3024);

    // 5. JR held by a two-cycle stall while the forwarded rs settles
    npc_op = 3'd4; rs_fwd = 32'h0000_1234; stall = 1'b1;
    instr_F = 32'hAAAA_5555;
    step();
    check("jr_st1_pc_F", pc_F, 32'h0000_3000);
    check("jr_st1_pc_D", pc_D, 32'h0000_3024);
    check("jr_st1_pc8_D", pc8_D, 32'h0000_302C);
    rs_fwd = 32'h0000_4000;
    step();
    check("jr_st2_pc_F", pc_F, 32'h0000_3000);
    check("jr_st2_instr_D", instr_D, 32'hC0DE_0005 + 32'h0);
    check("jr_st2_pc8_D", pc8_D, 32'h0000_302C);
    stall = 1'b0;
    step();
    check("jr_pc_F", pc_F, 32'h0000_4000);
    check("jr_pc_D", pc_D, 32'h0000_3000);
    check("jr_pc8_D", pc8_D, 32'h0000_3008);
    check("jr_instr_D", instr_D, 32'hAAAA_5555);

    // 6. wraparound at the top of the address space
    rs_fwd = 32'hFFFF_FFFC;
    step();
    check("wrap_pre_pc_F", pc_F, 32'hFFFF_FFFC);
    npc_op = 3'd0; cmp_zero = 1'b1; imm16 = 16'h7FFF; index26 = 26'h3FFFFFF; rs_fwd = 32'h1111_1111;
    step();
    check("wrap_pc_F", pc_F, 32'h0000_0000);
    check("wrap_pc8_D", pc8_D, 32'h0000_0004);
    npc_op = 3'd7;
    step();
    check("op7_pc_F", pc_F, 32'h0000_0004);
    check("op7_pc_D", pc_D, 32'h0000_0000);
    // negative offset below zero wraps: 0 + 4 - 16
    npc_op = 3'd1; cmp_zero = 1'b1; imm16 = 16'hFFFC;
    step();
    check("negwrap_pc_F", pc_F, 32'hFFFF_FFF4);

    // reset while a taken branch is presented
    do_reset();
    seq_steps(3);
    npc_op = 3'd1; imm16 = 16'h0003; cmp_zero = 1'b1;
    #1;
    reset = 1'b1;
    #1;
    check("rst_br_pc_F", pc_F, 32'h0000_3000);
    npc_op = 3'd0;
    #1;
    reset = 1'b0;
    check("rst_br_redirect", {31'b0, redirect}, 32'h0);
    step();
    check("rst_br_after_pc_F", pc_F, 32'h0000_3004);
    check("rst_br_after_pc_D", pc_D, 32'h0000_3000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
